// File: rtl/auto_dark_invert.sv
// Brightness-adaptive video inverter: two-stage sync/data pipeline plus per-frame luma averaging
// that decides, with hysteresis, whether the following frame is shown inverted.
module auto_dark_invert #(
    parameter logic [7:0] TH_HI  = 8'd160,
    parameter logic [7:0] TH_LO  = 8'd96,
    parameter int         CNT_W  = 21,
    parameter int         ACC_W  = 29,
    parameter logic       VS_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  mode_i,
    input  logic        vin_hs_i,
    input  logic        vin_vs_i,
    input  logic        vin_de_i,
    input  logic [23:0] vin_data_i,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic        vout_de_o,
    output logic [23:0] vout_data_o,
    output logic        dark_o
);
    localparam int PROD_W = CNT_W + 8;

    logic             hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    logic [23:0]      data1_q, data1_d;
    logic [1:0]       mode1_q, mode1_d;
    logic             hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic [23:0]      data2_q, data2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
    logic [ACC_W-1:0] acc_q, acc_d, base_acc;
    logic [ACC_W:0]   acc_sum;
    logic             inv_q, inv_d, fv_q, fv_d;
    logic [10:0]      luma_sum;
    logic [7:0]       luma;
    logic [PROD_W-1:0] prod_hi, prod_lo;
    logic             vs_edge, frozen, eff_inv;

    always_comb begin
        // Y = (2R + 5G + B) >> 3 with input packed as {R, B, G}
        luma_sum = 11'({vin_data_i[23:16], 1'b0}) + 11'(vin_data_i[7:0]) * 11'd5
                 + 11'(vin_data_i[15:8]);
        luma     = 8'(luma_sum >> 3);

        vs_edge  = (vin_vs_i == VS_POL) && (vs1_q != VS_POL);
        prod_hi  = PROD_W'(cnt_q) * PROD_W'(TH_HI);
        prod_lo  = PROD_W'(cnt_q) * PROD_W'(TH_LO);

        inv_d = inv_q;
        fv_d  = fv_q;
        if (vs_edge) begin
            if (fv_q && (cnt_q != '0)) begin
                if (!inv_q && (PROD_W'(acc_q) >= prod_hi))
                    inv_d = 1'b1;
                else if (inv_q && (PROD_W'(acc_q) < prod_lo))
                    inv_d = 1'b0;
            end
            fv_d = 1'b1;
        end

        // The boundary pixel itself belongs to the new frame, so clear first, then accumulate.
        base_cnt = vs_edge ? '0 : cnt_q;
        base_acc = vs_edge ? '0 : acc_q;
        frozen   = (&base_cnt) || (&base_acc);
        acc_sum  = {1'b0, base_acc} + (ACC_W + 1)'(luma);
        cnt_d    = base_cnt;
        acc_d    = base_acc;
        if (vin_de_i && !frozen) begin
            cnt_d = base_cnt + 1'b1;
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end

        hs1_d   = vin_hs_i;
        vs1_d   = vin_vs_i;
        de1_d   = vin_de_i;
        data1_d = vin_data_i;
        mode1_d = mode_i;

        eff_inv = (mode1_q == 2'b01) ? inv_q : (mode1_q == 2'b10);
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        de2_d   = de1_q;
        data2_d = data1_q ^ {24{eff_inv}};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            de1_q   <= 1'b0;
            data1_q <= '0;
            mode1_q <= '0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            de2_q   <= 1'b0;
            data2_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            inv_q   <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            de1_q   <= de1_d;
            data1_q <= data1_d;
            mode1_q <= mode1_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            de2_q   <= de2_d;
            data2_q <= data2_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            inv_q   <= inv_d;
            fv_q    <= fv_d;
        end
    end

    assign vout_hs_o   = hs2_q;
    assign vout_vs_o   = vs2_q;
    assign vout_de_o   = de2_q;
    assign vout_data_o = data2_q;
    assign dark_o      = inv_q;
endmodule

// File: tb/tb_auto_dark_invert.sv
// Scoreboard bench for auto_dark_invert: a behavioural frame model predicts every output word
// two cycles ahead and the inversion state; a narrow-counter instance exercises saturation.
module tb_auto_dark_invert;
    localparam longint CNT_MAX = (64'd1 << 21) - 1;
    localparam longint ACC_MAX = (64'd1 << 29) - 1;

    logic        clk_i = 1'b0;
    logic        rst_i, vin_hs_i, vin_vs_i, vin_de_i;
    logic [1:0]  mode_i;
    logic [23:0] vin_data_i;
    logic        vout_hs_o, vout_vs_o, vout_de_o, dark_o;
    logic [23:0] vout_data_o;
    logic        sat_hs, sat_vs, sat_de, sat_dark;
    logic [23:0] sat_data;

    always #5 clk_i = ~clk_i;

    auto_dark_invert u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
        .vin_hs_i(vin_hs_i), .vin_vs_i(vin_vs_i), .vin_de_i(vin_de_i), .vin_data_i(vin_data_i),
        .vout_hs_o(vout_hs_o), .vout_vs_o(vout_vs_o), .vout_de_o(vout_de_o),
        .vout_data_o(vout_data_o), .dark_o(dark_o)
    );

    auto_dark_invert #(.CNT_W(4), .ACC_W(12)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
        .vin_hs_i(vin_hs_i), .vin_vs_i(vin_vs_i), .vin_de_i(vin_de_i), .vin_data_i(vin_data_i),
        .vout_hs_o(sat_hs), .vout_vs_o(sat_vs), .vout_de_o(sat_de),
        .vout_data_o(sat_data), .dark_o(sat_dark)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int step_no  = 0;

    logic [26:0] exp_q[$];
    logic        m_inv, m_fv, m_prev_vs;
    longint      m_acc, m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic model_reset();
        m_inv = 1'b0; m_fv = 1'b0; m_prev_vs = 1'b0; m_acc = 0; m_cnt = 0;
    endtask

    // One clock: drive, predict, then compare the word that left the pipeline this cycle.
    task automatic step(input logic rst, input logic [1:0] mode, input logic hs, input logic vs,
                        input logic de, input logic [23:0] data);
        longint y;
        logic   eff;
        logic [26:0] exp_word;
        @(negedge clk_i);
        rst_i = rst; mode_i = mode; vin_hs_i = hs; vin_vs_i = vs; vin_de_i = de; vin_data_i = data;
        if (rst) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
        end else begin
            if (vs && !m_prev_vs) begin
                if (m_fv && m_cnt != 0) begin
                    if (!m_inv && m_acc >= m_cnt * 160) m_inv = 1'b1;
                    else if (m_inv && m_acc < m_cnt * 96) m_inv = 1'b0;
                end
                m_acc = 0; m_cnt = 0; m_fv = 1'b1;
            end
            m_prev_vs = vs;
            if (de && m_cnt != CNT_MAX && m_acc != ACC_MAX) begin
                y = (2 * longint'(data[23:16]) + 5 * longint'(data[7:0]) + longint'(data[15:8])) >> 3;
                m_cnt = m_cnt + 1;
                m_acc = (m_acc + y > ACC_MAX) ? ACC_MAX : m_acc + y;
            end
            eff = (mode == 2'b01) ? m_inv : (mode == 2'b10);
            exp_q.push_back({hs, vs, de, data ^ {24{eff}}});
        end
        @(posedge clk_i);
        #1;
        step_no++;
        exp_word = exp_q.pop_front();
        $display("step %0d rst=%0b mode=%0d vs=%0b de=%0b din=%h dout=%h exp=%h dark=%0b",
                 step_no, rst, mode, vs, de, data, vout_data_o, exp_word[23:0], dark_o);
        check_eq("vout", {5'b0, vout_hs_o, vout_vs_o, vout_de_o, vout_data_o}, {5'b0, exp_word});
        check_eq("dark", {31'b0, dark_o}, {31'b0, m_inv});
    endtask

    task automatic vs_pulse(input logic [1:0] mode);
        step(1'b0, mode, 1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, mode, 1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, mode, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic pixels(input logic [1:0] mode, input int n, input logic [23:0] data);
        for (int i = 0; i < n; i++) step(1'b0, mode, (i % 16) < 2, 1'b0, 1'b1, data);
        step(1'b0, mode, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 24'h0);
        check_eq("reset_data", {8'b0, vout_data_o}, 32'h0);
        check_eq("reset_dark", {31'b0, dark_o}, 32'h0);

        // Pass-through with a ramp and irregular de/hs
        for (int i = 0; i < 40; i++)
            step(1'b0, 2'b00, (i % 8) < 2, 1'b0, (i % 5) != 0, 24'(i * 32'h010203));

        // Auto mode, three white frames; the boundary pixel carries de=1
        step(1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 24'h0);
        check_eq("f1_no_decision", {31'b0, dark_o}, 32'h0);
        pixels(2'b01, 63, 24'hFFFFFF);
        vs_pulse(2'b01);
        check_eq("f2_dark", {31'b0, dark_o}, 32'h1);
        pixels(2'b01, 64, 24'hFFFFFF);
        check_eq("f3_black", {8'b0, vout_data_o}, 32'h0);

        // Hysteresis: mean 120 holds inversion, mean 90 releases it
        vs_pulse(2'b01);
        pixels(2'b01, 64, 24'h787878);
        vs_pulse(2'b01);
        check_eq("hyst_hold", {31'b0, dark_o}, 32'h1);
        pixels(2'b01, 64, 24'h5A5A5A);
        vs_pulse(2'b01);
        check_eq("hyst_clear", {31'b0, dark_o}, 32'h0);

        // Empty frame leaves state alone; forced invert on random data
        for (int i = 0; i < 10; i++) step(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        vs_pulse(2'b01);
        check_eq("empty_frame", {31'b0, dark_o}, 32'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 24'($urandom));

        // Reset in the middle of a white frame
        vs_pulse(2'b01);
        pixels(2'b01, 30, 24'hFFFFFF);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        check_eq("midrst_data", {8'b0, vout_data_o}, 32'h0);
        pixels(2'b01, 20, 24'hFFFFFF);
        vs_pulse(2'b01);
        check_eq("partial_no_decision", {31'b0, dark_o}, 32'h0);
        pixels(2'b01, 64, 24'hFFFFFF);
        vs_pulse(2'b01);
        check_eq("after_rst_decides", {31'b0, dark_o}, 32'h1);

        // Saturation on the 4-bit counter instance
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 24'h0);
        vs_pulse(2'b01);
        pixels(2'b01, 20, 24'hFFFFFF);
        check_eq("sat_cnt", 32'(u_sat.cnt_q), 32'd15);
        check_eq("sat_acc", 32'(u_sat.acc_q), 32'd3825);
        check_eq("sat_dark_before", {31'b0, sat_dark}, 32'h0);
        vs_pulse(2'b01);
        check_eq("sat_dark_after", {31'b0, sat_dark}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
